serial_adder_n: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor to the single-bit half-adder cell. It processes BITS_PER_CYCLE bits per clock through one carry-chained slice and a registered carry, trading latency for area. Operands arrive and results leave through valid/ready handshakes. It is the arithmetic leaf for small datapaths that do not need a full-width combinational adder.

---
 rtl/serial_adder_n_if.sv | 35 +++
 rtl/serial_adder_n.sv | 111 +++++++++++
 tb/tb_serial_adder_n.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_n_if.sv
// ============================================================================
//  Module   : serial_adder_n_if
//  Brief    : Operand/result handshake bundle for the bit-serial adder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder_n.sv
// ============================================================================
//  Module   : serial_adder_n
//  Brief    : Bit-serial add/subtract, BITS_PER_CYCLE bits per clock.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder_n #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input wire logic          clk,
    input wire logic          rst,
    serial_adder_n_if.slave   bus
);
    localparam int c_bpc   = BITS_PER_CYCLE;
    localparam int c_steps = WIDTH / c_bpc;
    localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    generate
        if (WIDTH < 2 || c_bpc < 1 || (WIDTH % c_bpc) != 0) begin : g_bad_params
            $error("serial_adder_n: BITS_PER_CYCLE must divide WIDTH and WIDTH >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_sub;
    logic               r_cout;
    logic               r_ovf;

    logic [c_bpc:0]     w_grp;
    logic [WIDTH-1:0]   w_grp_ext;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_cmsb;
    logic               w_last;
    logic               w_accept;

    assign w_grp = {1'b0, r_a[c_bpc-1:0]} + {1'b0, r_b[c_bpc-1:0]} + (c_bpc+1)'(r_carry);
    // Carry into the group's top bit recovered from its sum bit and operand bits.
    assign w_cmsb     = r_a[c_bpc-1] ^ r_b[c_bpc-1] ^ w_grp[c_bpc-1];
    assign w_grp_ext  = WIDTH'(w_grp[c_bpc-1:0]) << (WIDTH - c_bpc);
    assign w_sum_next = (r_sum >> c_bpc) | w_grp_ext;
    assign w_last     = (r_cnt == c_last);
    assign w_accept   = (r_state == S_IDLE) && bus.in_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.sub ? ~bus.b : bus.b;
                r_carry <= bus.sub ^ bus.cin;
                r_sub   <= bus.sub;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> c_bpc;
                r_b     <= r_b >> c_bpc;
                r_sum   <= w_sum_next;
                r_carry <= w_grp[c_bpc];
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_cout <= w_grp[c_bpc] ^ r_sub;
                    r_ovf  <= w_cmsb ^ w_grp[c_bpc];
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_n.sv
// ============================================================================
//  Module   : tb_serial_adder_n
//  Brief    : Scoreboard bench for three serial_adder_n configurations.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [9:0] q81[$];
    logic [9:0] q84[$];
    logic [9:0] q42[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_n_if #(.WIDTH(8)) if81 ();
    serial_adder_n_if #(.WIDTH(8)) if84 ();
    serial_adder_n_if #(.WIDTH(4)) if42 ();

    serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut81 (.clk(clk), .rst(rst), .bus(if81));
    serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut84 (.clk(clk), .rst(rst), .bus(if84));
    serial_adder_n #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut42 (.clk(clk), .rst(rst), .bus(if42));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference from integer semantics: returns {overflow, cout, sum}.
    function automatic logic [9:0] model(input int w, input int a, input int b,
                                         input bit s, input bit c);
        int  mask = (1 << w) - 1;
        int  half = 1 << (w - 1);
        int  sa   = (a >= half) ? a - (1 << w) : a;
        int  sb   = (b >= half) ? b - (1 << w) : b;
        int  ures = s ? (a - b - int'(c)) : (a + b + int'(c));
        int  sres = s ? (sa - sb - int'(c)) : (sa + sb + int'(c));
        bit  cy   = s ? (ures < 0) : (ures > mask);
        bit  ov   = (sres >= half) || (sres < -half);
        logic [7:0] sm = 8'(ures & mask);
        return {ov, cy, sm};
    endfunction

    task automatic op81(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c, input int hold);
        int n;
        int t0;
        logic [9:0] e;
        logic [7:0] hs;
        logic hc, ho;
        n = 0;
        while (if81.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("rdy81", if81.in_ready, 1);
        if81.a = a; if81.b = b; if81.sub = s; if81.cin = c; if81.in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        q81.push_back(model(8, int'(a), int'(b), s, c));
        if81.in_valid = 1'b0; if81.a = ~a; if81.b = ~b; if81.sub = ~s; if81.cin = ~c;
        n = 0;
        while (if81.out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check("lat81", cyc - t0, 8);
        e = (q81.size() > 0) ? q81.pop_front() : 'x;
        check("sum81", if81.sum, e[7:0]);
        check("cout81", if81.cout, e[8]);
        check("ovf81", if81.overflow, e[9]);
        hs = if81.sum; hc = if81.cout; ho = if81.overflow;
        for (int i = 0; i < hold; i++) begin
            if81.in_valid = i[0]; if81.a = 8'($urandom); if81.b = 8'($urandom);
            @(posedge clk); #1;
            check("hold_sum81", if81.sum, hs);
            check("hold_cout81", if81.cout, hc);
            check("hold_ovf81", if81.overflow, ho);
            check("hold_rdy81", if81.in_ready, 0);
            check("hold_ov81", if81.out_valid, 1);
        end
        if81.in_valid = 1'b0; if81.out_ready = 1'b1;
        @(posedge clk); #1;
        if81.out_ready = 1'b0;
        check("ovdrop81", if81.out_valid, 0);
        check("idle81", if81.busy, 0);
        check("idlerdy81", if81.in_ready, 1);
    endtask

    task automatic op84(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
        int n;
        int t0;
        logic [9:0] e;
        if84.a = a; if84.b = b; if84.sub = s; if84.cin = c; if84.in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        q84.push_back(model(8, int'(a), int'(b), s, c));
        if84.in_valid = 1'b0;
        n = 0;
        while (if84.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("lat84", cyc - t0, 2);
        e = (q84.size() > 0) ? q84.pop_front() : 'x;
        check("sum84", if84.sum, e[7:0]);
        check("cout84", if84.cout, e[8]);
        check("ovf84", if84.overflow, e[9]);
        if84.out_ready = 1'b1;
        @(posedge clk); #1;
        if84.out_ready = 1'b0;
        check("rdy84", if84.in_ready, 1);
    endtask

    task automatic op42(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c);
        int n;
        int t0;
        logic [9:0] e;
        if42.a = a; if42.b = b; if42.sub = s; if42.cin = c; if42.in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        q42.push_back(model(4, int'(a), int'(b), s, c));
        if42.in_valid = 1'b0;
        n = 0;
        while (if42.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("lat42", cyc - t0, 2);
        e = (q42.size() > 0) ? q42.pop_front() : 'x;
        check("sum42", if42.sum, e[3:0]);
        check("cout42", if42.cout, e[8]);
        check("ovf42", if42.overflow, e[9]);
        if42.out_ready = 1'b1;
        @(posedge clk); #1;
        if42.out_ready = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        if81.in_valid = 0; if81.a = 0; if81.b = 0; if81.sub = 0; if81.cin = 0; if81.out_ready = 0;
        if84.in_valid = 0; if84.a = 0; if84.b = 0; if84.sub = 0; if84.cin = 0; if84.out_ready = 0;
        if42.in_valid = 0; if42.a = 0; if42.b = 0; if42.sub = 0; if42.cin = 0; if42.out_ready = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", if81.in_ready, 0);
        check("rst_ov", if81.out_valid, 0);
        check("rst_busy", if81.busy, 0);
        check("rst_sum", if81.sum, 0);
        check("rst_cout", if81.cout, 0);
        check("rst_ovf", if81.overflow, 0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", if81.in_ready, 1);

        op81(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        op81(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        op81(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        op81(8'hFF, 8'hFF, 1'b0, 1'b1, 0);
        op81(8'h05, 8'h07, 1'b1, 1'b0, 0);
        op81(8'h80, 8'h01, 1'b1, 1'b0, 5);
        op81(8'h33, 8'h44, 1'b0, 1'b0, 0);

        // Abort at RUN step 3, with in_valid colliding with reset.
        if81.a = 8'h12; if81.b = 8'h34; if81.sub = 0; if81.cin = 0; if81.in_valid = 1'b1;
        @(posedge clk); #1;
        if81.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; if81.in_valid = 1'b1;
        @(posedge clk); #1;
        check("abort_rdy", if81.in_ready, 0);
        check("abort_busy", if81.busy, 0);
        check("abort_sum", if81.sum, 0);
        check("abort_cout", if81.cout, 0);
        check("abort_ovf", if81.overflow, 0);
        rst = 1'b0; if81.in_valid = 1'b0;
        #1;
        check("abort_rdy_after", if81.in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_no_ov", if81.out_valid, 0);
        end
        op81(8'h80, 8'h80, 1'b0, 1'b0, 0);

        for (int i = 0; i < 10; i++)
            op81(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        op84(8'h0F, 8'h01, 1'b0, 1'b0);
        op84(8'h7F, 8'h01, 1'b0, 1'b0);
        op84(8'h05, 8'h07, 1'b1, 1'b0);
        op84(8'hFF, 8'hFF, 1'b0, 1'b1);
        op84(8'h80, 8'h01, 1'b1, 1'b1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int sc = 0; sc < 4; sc++)
                    op42(4'(a), 4'(b), sc[1], sc[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
